ppu_vga_scaler: RTL and testbench

- Parametrised next-generation VGA output stage for the PPU.
- Integrates its own timing generator, so no external sync block is needed.
- Maps NES pixel coordinates onto a configurable display at 1x or 2x with programmable border colour and an optional scanline-darkening mode.
- Outputs NES coordinates, pixel pulse and a vblank window whose set/clear points are parameters. Sits between the PPU renderer and the VGA pins.

---
 rtl/ppu_vga_scaler.sv | 163 ++++++++++++++++
 tb/tb_ppu_vga_scaler.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/ppu_vga_scaler.sv
// ppu_vga_scaler: VGA timing plus 1x/2x NES-frame mapping, border and scanline colour stage.
// Define PPU_VGA_SCALER_PAL_WR_EN to make the palette a writable 64x12 register file.
module ppu_vga_scaler #(
  parameter int COLOR_W    = 4,
  parameter int PIX_DIV    = 2,
  parameter int H_DISP     = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_DISP     = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int NES_W      = 256,
  parameter int NES_H      = 240,
  parameter int CROP_LINES = 8,
  parameter int VBL_SET_X  = 730,
  parameter int VBL_SET_Y  = 477,
  parameter int VBL_CLR_X  = 64,
  parameter int VBL_CLR_Y  = 519
) (
  input  logic                   clk_in,
  input  logic                   rst_n_in,
  input  logic                   scale_in,
  input  logic                   scanline_in,
  input  logic [3*COLOR_W-1:0]   border_rgb_in,
  input  logic [5:0]             sys_palette_idx_in,
`ifdef PPU_VGA_SCALER_PAL_WR_EN
  input  logic                   pal_wr_in,
  input  logic [5:0]             pal_addr_in,
  input  logic [11:0]            pal_data_in,
`endif
  output logic                   hsync_out,
  output logic                   vsync_out,
  output logic [COLOR_W-1:0]     r_out,
  output logic [COLOR_W-1:0]     g_out,
  output logic [COLOR_W-1:0]     b_out,
  output logic [9:0]             nes_x_out,
  output logic [9:0]             nes_y_out,
  output logic [9:0]             nes_y_next_out,
  output logic                   pix_pulse_out,
  output logic                   vblank_out
);
  localparam int H_TOT = H_DISP + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_DISP + V_FP + V_SYNC + V_BP;
  localparam int DW    = PIX_DIV > 1 ? $clog2(PIX_DIV) : 1;
  localparam int CW    = 3 * COLOR_W;
  localparam logic [11:0] PAL_ROM [64] = '{
    12'h666, 12'h218, 12'h30A, 12'h509, 12'h707, 12'h804, 12'h800, 12'h610,
    12'h420, 12'h230, 12'h040, 12'h041, 12'h034, 12'h000, 12'h000, 12'h000,
    12'hAAA, 12'h14D, 12'h53F, 12'h82E, 12'hA2B, 12'hC26, 12'hC30, 12'hA50,
    12'h770, 12'h480, 12'h390, 12'h384, 12'h278, 12'h000, 12'h000, 12'h000,
    12'hFFF, 12'h5AF, 12'h89F, 12'hB6F, 12'hF6F, 12'hF7B, 12'hF85, 12'hEA4,
    12'hCC3, 12'h9D3, 12'h6E5, 12'h5E9, 12'h4DD, 12'h000, 12'h000, 12'h000,
    12'hFFF, 12'hBEF, 12'hCDF, 12'hDCF, 12'hFCF, 12'hFCD, 12'hFCB, 12'hFDA,
    12'hEE9, 12'hCE9, 12'hBFB, 12'hBFD, 12'hBEE, 12'h000, 12'h000, 12'h000
  };

  logic [DW-1:0] div_q, div_d;
  logic [9:0]    x_q, x_d, y_q, y_d;
  logic          hs_q, hs_d, vs_q, vs_d, vbl_q, vbl_d, sc_q, sc_d, sl_q, sl_d;
  logic [CW-1:0] brd_q, brd_d, rgb_q, rgb_d;
  logic          tick, x_wrap, y_wrap, frame, en, border, dim;
  logic [9:0]    x_nxt, y_nxt, nes_x_nxt;
  logic [11:0]   pal_rd;
  logic [CW-1:0] pix_rgb, dim_rgb;

  // Centre the scaled NES frame: offset is half the unused display span.
  function automatic logic [9:0] nes_map(input logic [9:0] p, input logic [9:0] disp,
                                         input logic [9:0] nes, input logic s);
    logic [9:0] off;
    off = (disp - (nes << s)) >> 1;
    return (p - off) >> s;
  endfunction

  function automatic logic [COLOR_W-1:0] ext(input logic [3:0] v);
    logic [COLOR_W-1:0] o;
    for (int i = 0; i < COLOR_W; i++) o[COLOR_W-1-i] = v[3-(i%4)];
    return o;
  endfunction

`ifdef PPU_VGA_SCALER_PAL_WR_EN
  logic [11:0] pal_q [64];
  logic [11:0] pal_d [64];
  always_comb begin
    pal_d = pal_q;
    if (pal_wr_in) pal_d[pal_addr_in] = pal_data_in;
  end
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) pal_q <= PAL_ROM;
    else pal_q <= pal_d;
  end
  assign pal_rd = pal_q[sys_palette_idx_in];
`else
  assign pal_rd = PAL_ROM[sys_palette_idx_in];
`endif

  always_comb begin
    tick           = div_q == DW'(PIX_DIV - 1);
    x_wrap         = x_q == 10'(H_TOT - 1);
    y_wrap         = y_q == 10'(V_TOT - 1);
    frame          = tick && x_wrap && y_wrap;
    x_nxt          = x_wrap ? 10'd0 : x_q + 10'd1;
    y_nxt          = y_wrap ? 10'd0 : y_q + 10'd1;
    div_d          = tick ? '0 : div_q + DW'(1);
    x_d            = tick ? x_nxt : x_q;
    y_d            = tick && x_wrap ? y_nxt : y_q;
    en             = x_q < 10'(H_DISP) && y_q < 10'(V_DISP);
    nes_x_out      = nes_map(x_q, 10'(H_DISP), 10'(NES_W), sc_q);
    nes_x_nxt      = nes_map(x_nxt, 10'(H_DISP), 10'(NES_W), sc_q);
    nes_y_out      = nes_map(y_q, 10'(V_DISP), 10'(NES_H), sc_q);
    nes_y_next_out = nes_map(y_nxt, 10'(V_DISP), 10'(NES_H), sc_q);
    // Gated by reset so a PIX_DIV=1 build cannot pulse while held in reset.
    pix_pulse_out  = tick && rst_n_in && nes_x_nxt != nes_x_out;
    border         = nes_x_out >= 10'(NES_W) || nes_y_out < 10'(CROP_LINES) ||
                     nes_y_out >= 10'(NES_H - CROP_LINES);
    dim            = sc_q && sl_q && y_q[0];
    pix_rgb        = {ext(pal_rd[11:8]), ext(pal_rd[7:4]), ext(pal_rd[3:0])};
    dim_rgb        = {ext(pal_rd[11:8]) >> 1, ext(pal_rd[7:4]) >> 1, ext(pal_rd[3:0]) >> 1};
    rgb_d          = !tick ? rgb_q : !en ? '0 : border ? brd_q : dim ? dim_rgb : pix_rgb;
    hs_d           = tick ? !(x_q >= 10'(H_DISP + H_FP) && x_q < 10'(H_DISP + H_FP + H_SYNC)) : hs_q;
    vs_d           = tick ? !(y_q >= 10'(V_DISP + V_FP) && y_q < 10'(V_DISP + V_FP + V_SYNC)) : vs_q;
    vbl_d          = !tick ? vbl_q :
                     (x_q == 10'(VBL_SET_X) && y_q == 10'(VBL_SET_Y)) ? 1'b1 :
                     (x_q == 10'(VBL_CLR_X) && y_q == 10'(VBL_CLR_Y)) ? 1'b0 : vbl_q;
    sc_d           = frame ? scale_in : sc_q;
    sl_d           = frame ? scanline_in : sl_q;
    brd_d          = frame ? border_rgb_in : brd_q;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      div_q <= '0;
      x_q   <= '0;
      y_q   <= '0;
      hs_q  <= 1'b1;
      vs_q  <= 1'b1;
      rgb_q <= '0;
      vbl_q <= 1'b0;
      sc_q  <= 1'b0;
      sl_q  <= 1'b0;
      brd_q <= '0;
    end else begin
      div_q <= div_d;
      x_q   <= x_d;
      y_q   <= y_d;
      hs_q  <= hs_d;
      vs_q  <= vs_d;
      rgb_q <= rgb_d;
      vbl_q <= vbl_d;
      sc_q  <= sc_d;
      sl_q  <= sl_d;
      brd_q <= brd_d;
    end
  end

  assign hsync_out  = hs_q;
  assign vsync_out  = vs_q;
  assign vblank_out = vbl_q;
  assign r_out      = rgb_q[CW-1 -: COLOR_W];
  assign g_out      = rgb_q[2*COLOR_W-1 -: COLOR_W];
  assign b_out      = rgb_q[COLOR_W-1:0];
endmodule

// File: tb/tb_ppu_vga_scaler.sv
// tb_ppu_vga_scaler: randomized check of a shrunken-timing ppu_vga_scaler against a frame-position model.
module tb_ppu_vga_scaler;
  localparam int PD = 2;
  localparam int HD = 48, HF = 4, HS = 8, HB = 4;
  localparam int VD = 28, VF = 2, VS = 2, VB = 3;
  localparam int NW = 16, NH = 12, CR = 2;
  localparam int SX = 50, SY = 27, CX = 8, CY = 34;
  localparam int HT = HD + HF + HS + HB;
  localparam int VT = VD + VF + VS + VB;
  localparam int FR = HT * VT * PD;
  localparam int PAL_DEF [64] = '{
    'h666, 'h218, 'h30A, 'h509, 'h707, 'h804, 'h800, 'h610,
    'h420, 'h230, 'h040, 'h041, 'h034, 'h000, 'h000, 'h000,
    'hAAA, 'h14D, 'h53F, 'h82E, 'hA2B, 'hC26, 'hC30, 'hA50,
    'h770, 'h480, 'h390, 'h384, 'h278, 'h000, 'h000, 'h000,
    'hFFF, 'h5AF, 'h89F, 'hB6F, 'hF6F, 'hF7B, 'hF85, 'hEA4,
    'hCC3, 'h9D3, 'h6E5, 'h5E9, 'h4DD, 'h000, 'h000, 'h000,
    'hFFF, 'hBEF, 'hCDF, 'hDCF, 'hFCF, 'hFCD, 'hFCB, 'hFDA,
    'hEE9, 'hCE9, 'hBFB, 'hBFD, 'hBEE, 'h000, 'h000, 'h000
  };

  logic        clk = 0, rst_n = 0, scale = 0, scanline = 0;
  logic [11:0] border = 0;
  logic [5:0]  idx = 0;
  logic        hsync, vsync, pulse, vblank;
  logic [3:0]  r, g, b;
  logic [9:0]  nes_x, nes_y, nes_y_next;
`ifdef PPU_VGA_SCALER_PAL_WR_EN
  logic        pal_wr = 0;
  logic [5:0]  pal_addr = 0;
  logic [11:0] pal_data = 0;
`endif

  ppu_vga_scaler #(
    .COLOR_W(4), .PIX_DIV(PD), .H_DISP(HD), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_DISP(VD), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .NES_W(NW), .NES_H(NH),
    .CROP_LINES(CR), .VBL_SET_X(SX), .VBL_SET_Y(SY), .VBL_CLR_X(CX), .VBL_CLR_Y(CY)
  ) dut (
    .clk_in(clk), .rst_n_in(rst_n), .scale_in(scale), .scanline_in(scanline),
    .border_rgb_in(border), .sys_palette_idx_in(idx),
`ifdef PPU_VGA_SCALER_PAL_WR_EN
    .pal_wr_in(pal_wr), .pal_addr_in(pal_addr), .pal_data_in(pal_data),
`endif
    .hsync_out(hsync), .vsync_out(vsync), .r_out(r), .g_out(g), .b_out(b),
    .nes_x_out(nes_x), .nes_y_out(nes_y), .nes_y_next_out(nes_y_next),
    .pix_pulse_out(pulse), .vblank_out(vblank)
  );

  always #5 clk = ~clk;

  int tests, fails, cnt;
  int m_sc, m_sl, m_brd, m_hs, m_vs, m_rgb, m_vbl;
  int pal [64];

  function automatic int nmap(int p, int disp, int nes, int s);
    return ((p - (disp - (nes << s)) / 2) & 1023) >> s;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s cnt=%0d got=%h exp=%h", tag, cnt, got, exp);
    end
  endtask

  task automatic model_reset();
    cnt = 0; m_sc = 0; m_sl = 0; m_brd = 0;
    m_hs = 1; m_vs = 1; m_rgb = 0; m_vbl = 0;
    pal = PAL_DEF;
  endtask

  task automatic step();
    int p, x, y, nx, ny, c;
    p = cnt / PD; x = p % HT; y = (p / HT) % VT;
    if (cnt % PD == PD - 1) begin
      nx = nmap(x, HD, NW, m_sc);
      ny = nmap(y, VD, NH, m_sc);
      c = pal[idx];
      if (!(x < HD && y < VD)) m_rgb = 0;
      else if (nx >= NW || ny < CR || ny >= NH - CR) m_rgb = m_brd;
      else m_rgb = (m_sc == 1 && m_sl == 1 && y % 2 == 1) ? (c >> 1) & 'h777 : c;
      m_hs = (x >= HD + HF && x < HD + HF + HS) ? 0 : 1;
      m_vs = (y >= VD + VF && y < VD + VF + VS) ? 0 : 1;
      if (x == SX && y == SY) m_vbl = 1;
      else if (x == CX && y == CY) m_vbl = 0;
      if (x == HT - 1 && y == VT - 1) begin
        m_sc = int'(scale); m_sl = int'(scanline); m_brd = int'(border);
      end
    end
`ifdef PPU_VGA_SCALER_PAL_WR_EN
    if (pal_wr) pal[pal_addr] = int'(pal_data);
`endif
    cnt++;
  endtask

  task automatic compare();
    int p, x, y, xn, yn, ep;
    p = cnt / PD; x = p % HT; y = (p / HT) % VT;
    xn = (x + 1) % HT; yn = (y + 1) % VT;
    ep = (cnt % PD == PD - 1 && nmap(xn, HD, NW, m_sc) != nmap(x, HD, NW, m_sc)) ? 1 : 0;
    check("hsync", 32'(hsync), 32'(m_hs));
    check("vsync", 32'(vsync), 32'(m_vs));
    check("rgb", 32'({r, g, b}), 32'(m_rgb));
    check("vblank", 32'(vblank), 32'(m_vbl));
    check("nes_x", 32'(nes_x), 32'(nmap(x, HD, NW, m_sc)));
    check("nes_y", 32'(nes_y), 32'(nmap(y, VD, NH, m_sc)));
    check("nes_y_next", 32'(nes_y_next), 32'(nmap(yn, VD, NH, m_sc)));
    check("pix_pulse", 32'(pulse), 32'(ep));
  endtask

  task automatic check_reset();
    check("rst_hsync", 32'(hsync), 32'd1);
    check("rst_vsync", 32'(vsync), 32'd1);
    check("rst_rgb", 32'({r, g, b}), 32'd0);
    check("rst_vblank", 32'(vblank), 32'd0);
    check("rst_pulse", 32'(pulse), 32'd0);
    check("rst_nes_x", 32'(nes_x), 32'(nmap(0, HD, NW, 0)));
    check("rst_nes_y", 32'(nes_y), 32'(nmap(0, VD, NH, 0)));
  endtask

  task automatic drive();
    idx = 6'($urandom);
    if ($urandom_range(0, 199) == 0) border = 12'($urandom);
`ifdef PPU_VGA_SCALER_PAL_WR_EN
    pal_wr   = $urandom_range(0, 39) == 0;
    pal_addr = $urandom_range(0, 1) == 1 ? idx : 6'($urandom);
    pal_data = 12'($urandom);
`endif
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      step();
      @(negedge clk);
      compare();
      drive();
    end
  endtask

  initial begin
    tests = 0; fails = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check_reset();
    rst_n = 1;
    scale = 1; scanline = 1; border = 12'h5A3;
    run(FR / 2);
    run(FR + FR / 2);
    scanline = 0;
    run(FR);
    scale = 0;
    run(FR);
    scale = 1; scanline = 1;
    run(FR / 3);
    #2 rst_n = 0;
    model_reset();
    @(negedge clk);
    check_reset();
    rst_n = 1;
    run(2 * FR + 100);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
